multi_line_buffer: RTL and testbench
====================================

MULTI_LINE_BUFFER -- requirements
Module: multi_line_buffer

Interface
REQ-001 SHALL have parameter PIC_WIDTH, default 250, pixels per line (range 2..2047).
REQ-002 SHALL have parameter PIC_HEIGHT, default 250, lines per frame (range 2..2047).
REQ-003 SHALL have parameter DATA_W, default 24, pixel width in bits.
REQ-004 SHALL have parameter NUM_LINES, default 3, vertical window taps (range 2..7).
REQ-005 SHALL have port clk  input  1  clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port sof  input  1  start-of-frame; synchronous counter and priming clear.
REQ-008 SHALL have port din  input  DATA_W  incoming pixel, raster order.
REQ-009 SHALL have port din_valid  input  1  din qualifier and write enable; gaps allowed at any cycle.
REQ-010 SHALL have port dout  output  NUM_LINES*DATA_W  column window; slice k (bits k*DATA_W +: DATA_W) = pixel k rows above the current pixel, same column; slice 0 = current pixel.
REQ-011 SHALL have port dout_valid  output  1  dout qualifier.
REQ-012 SHALL have port col_out  output  11  column index of the pixel in dout.
REQ-013 SHALL have port row_out  output  11  row index of the pixel in dout slice 0.
REQ-014 SHALL have port frame_done  output  1  one-cycle pulse with the last pixel of a frame.

Function
REQ-015 SHALL keep internal col_cnt (0..PIC_WIDTH-1) and row_cnt (0..PIC_HEIGHT-1), both advancing only on din_valid.
REQ-016 SHALL wrap col_cnt to 0 after PIC_WIDTH-1 and increment row_cnt; row_cnt SHALL wrap to 0 after PIC_HEIGHT-1.
REQ-017 SHALL hold NUM_LINES-1 line stores of PIC_WIDTH x DATA_W; on din_valid at column c, store 0 SHALL read old [c] and write din, and store k SHALL read old [c] and write the pre-write read of store k-1 (read-before-write, same cycle).
REQ-018 SHALL register dout, col_out, row_out, dout_valid, frame_done: latency exactly 1 cycle from the din_valid edge.
REQ-019 SHALL assert dout_valid only for din_valid cycles with row_cnt >= NUM_LINES-1 (window primed); earlier rows SHALL still be written but not output.
REQ-020 SHALL pulse frame_done with the pixel at col PIC_WIDTH-1, row PIC_HEIGHT-1, then restart priming (next frame row 0 not output).
REQ-021 SHALL, when din_valid=0, hold dout, col_out, row_out, leave memory untouched, and drive dout_valid=0, frame_done=0.
REQ-022 SHALL, on sof=1, treat the current cycle as frame start: with din_valid=1 the pixel is col 0 row 0; with din_valid=0 counters go to 0; sof SHALL take priority over wrap logic.
REQ-023 SHALL not require line-store clearing on sof; stale data is masked by priming rule REQ-019.

Reset
REQ-024 SHALL on rst_n=0 clear col_cnt, row_cnt, dout, col_out, row_out, dout_valid, frame_done to 0 immediately.
REQ-025 SHALL not reset line-store contents; reset mid-frame SHALL behave as sof on the next valid pixel.

Structure
REQ-026 SHALL take the counter width (11) and parameter range limits from shared package img_pkg.
REQ-027 SHALL implement each line store as sub-module line_store (single-port, combinational read, synchronous write, depth PIC_WIDTH), instanced NUM_LINES-1 times by generate loop.
REQ-028 SHALL contain no vendor FIFO IP and no reset-busy handshake.

Verification (PIC_WIDTH=4, PIC_HEIGHT=4, NUM_LINES=3, DATA_W=8, din = row*16+col)
REQ-029 SHALL check continuous frame: first dout_valid 1 cycle after pixel (row2,col0); dout={0x00,0x10,0x20}; 8 valid outputs total, frame_done with dout={0x13,0x23,0x33}.
REQ-030 SHALL check random din_valid gaps (50%): output sequence identical to REQ-029, dout held during gaps.
REQ-031 SHALL check sof asserted mid-row 1 col 2 with din_valid: that pixel reported as row0 col0, no dout_valid until new row 2.
REQ-032 SHALL check rst_n low at row 3 col 1: all outputs 0 asynchronously; after release, frame restarts with priming, no stale output.
REQ-033 SHALL check back-to-back frames: second frame row 0/1 produce no dout_valid; row 2 col 0 gives {0x00,0x10,0x20} again.
REQ-034 SHALL check NUM_LINES=2 build: first dout_valid at row1 col0, dout={0x00,0x10}.

Source files
------------

// File: rtl/img_pkg.sv
// Shared image-pipeline constants: counter width, parameter limits, wrap helper.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package img_pkg;

  // Row/column counters are sized for the largest supported picture dimension.
  localparam int CNT_W = 11;

  // Legal parameter ranges for image blocks built on this package.
  localparam int MIN_DIM   = 2;
  localparam int MAX_DIM   = 2047;
  localparam int MIN_LINES = 2;
  localparam int MAX_LINES = 7;

  typedef logic [CNT_W-1:0] cnt_t;

  // Increment a counter, returning to zero once it has reached 'last'.
  function automatic cnt_t wrap_inc(input cnt_t v, input cnt_t last);
    return (v == last) ? '0 : v + cnt_t'(1);
  endfunction

endpackage

// File: rtl/line_store.sv
// One line of pixel storage: single port, combinational read, synchronous write.
// Latency: read data is valid in the same cycle as addr; writes land on the next rising edge.
// Backpressure: none; the caller's write enable is the only qualifier.
module line_store #(
  parameter int DEPTH  = 250,
  parameter int DATA_W = 24,
  parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  // Contents are deliberately not reset; stale data is masked upstream.
  logic [DATA_W-1:0] mem [DEPTH];

  // Old contents are visible during the write cycle, giving read-before-write.
  assign rdata = mem[addr];

  // Store the incoming word at the addressed column.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/multi_line_buffer.sv
// Vertical pixel window: emits the current pixel plus the same column from NUM_LINES-1 rows above.
// Latency: outputs registered, exactly one cycle after the accepted din_valid edge.
// Backpressure: none; din_valid gaps stall everything, outputs hold and valid drops during gaps.
module multi_line_buffer
  import img_pkg::*;
#(
  parameter int PIC_WIDTH  = 250,
  parameter int PIC_HEIGHT = 250,
  parameter int DATA_W     = 24,
  parameter int NUM_LINES  = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        sof,
  input  logic [DATA_W-1:0]           din,
  input  logic                        din_valid,
  output logic [NUM_LINES*DATA_W-1:0] dout,
  output logic                        dout_valid,
  output logic [CNT_W-1:0]            col_out,
  output logic [CNT_W-1:0]            row_out,
  output logic                        frame_done
);

  // Supported ranges: PIC_WIDTH/PIC_HEIGHT in MIN_DIM..MAX_DIM,
  // NUM_LINES in MIN_LINES..MAX_LINES (see img_pkg).
  localparam int   ADDR_W    = $clog2(PIC_WIDTH);
  localparam int   TAPS      = NUM_LINES - 1;
  localparam cnt_t LAST_COL  = cnt_t'(PIC_WIDTH - 1);
  localparam cnt_t LAST_ROW  = cnt_t'(PIC_HEIGHT - 1);
  localparam cnt_t PRIME_ROW = cnt_t'(NUM_LINES - 1);

  cnt_t col_cnt;
  cnt_t row_cnt;
  cnt_t col_cur;
  cnt_t row_cur;
  logic primed;
  logic last_pix;

  logic [DATA_W-1:0]           rd_dat [TAPS];
  logic [DATA_W-1:0]           wr_dat [TAPS];
  logic [NUM_LINES*DATA_W-1:0] window;

  // Position of the pixel on din this cycle; sof forces the frame origin.
  always_comb begin
    col_cur = sof ? '0 : col_cnt;
    row_cur = sof ? '0 : row_cnt;
  end

  // Window is complete once enough rows of this frame have been stored.
  assign primed   = (row_cur >= PRIME_ROW);
  assign last_pix = (col_cur == LAST_COL) && (row_cur == LAST_ROW);

  // Raster position counters; advance on accepted pixels, sof alone re-homes them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (din_valid) begin
      col_cnt <= wrap_inc(col_cur, LAST_COL);
      if (col_cur == LAST_COL) begin
        row_cnt <= wrap_inc(row_cur, LAST_ROW);
      end else begin
        row_cnt <= row_cur;
      end
    end else if (sof) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end
  end

  // Chain of line stores: each shifts its old column value into the next one.
  for (genvar k = 0; k < TAPS; k++) begin : g_store
    if (k == 0) begin : g_head
      assign wr_dat[k] = din;
    end else begin : g_chain
      assign wr_dat[k] = rd_dat[k-1];
    end

    line_store #(
      .DEPTH  (PIC_WIDTH),
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_line_store (
      .clk   (clk),
      .we    (din_valid),
      .addr  (col_cur[ADDR_W-1:0]),
      .wdata (wr_dat[k]),
      .rdata (rd_dat[k])
    );
  end

  // Assemble the column window: slice 0 is the live pixel, slice k is k rows up.
  always_comb begin
    window = '0;
    window[DATA_W-1:0] = din;
    for (int k = 1; k < NUM_LINES; k++) begin
      window[k*DATA_W +: DATA_W] = rd_dat[k-1];
    end
  end

  // Output register; data fields only change when a primed window is emitted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout       <= '0;
      col_out    <= '0;
      row_out    <= '0;
      dout_valid <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      dout_valid <= din_valid && primed;
      frame_done <= din_valid && last_pix;
      if (din_valid && primed) begin
        dout    <= window;
        col_out <= col_cur;
        row_out <= row_cur;
      end
    end
  end

endmodule

// File: tb/tb_multi_line_buffer.sv
// Bench for multi_line_buffer: 4x4 frames, 8-bit pixels, 3-line and 2-line builds side by side.
// Latency: expects outputs one cycle after each accepted pixel.
// Backpressure: stimulus inserts din_valid gaps; outputs must hold across them.
module tb_multi_line_buffer;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          sof;
  logic          din_valid;
  logic [DW-1:0] din;

  logic [3*DW-1:0] dout_a;
  logic            dv_a;
  logic            fd_a;
  logic [10:0]     col_a;
  logic [10:0]     row_a;

  logic [2*DW-1:0] dout_b;
  logic            dv_b;
  logic            fd_b;
  logic [10:0]     col_b;
  logic [10:0]     row_b;

  multi_line_buffer #(
    .PIC_WIDTH(W), .PIC_HEIGHT(H), .DATA_W(DW), .NUM_LINES(3)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .sof(sof), .din(din), .din_valid(din_valid),
    .dout(dout_a), .dout_valid(dv_a), .col_out(col_a), .row_out(row_a),
    .frame_done(fd_a)
  );

  multi_line_buffer #(
    .PIC_WIDTH(W), .PIC_HEIGHT(H), .DATA_W(DW), .NUM_LINES(2)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .sof(sof), .din(din), .din_valid(din_valid),
    .dout(dout_b), .dout_valid(dv_b), .col_out(col_b), .row_out(row_b),
    .frame_done(fd_b)
  );

  typedef struct {
    logic [23:0] d;
    logic [10:0] col;
    logic [10:0] row;
    logic        done;
  } exp_t;

  typedef struct {
    logic        s;
    logic        v;
    logic        xv;
    logic [23:0] xd;
    logic [10:0] xc;
    logic [10:0] xr;
    logic        xf;
    logic        chk;
  } vec_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t held_a;
  exp_t held_b;
  logic ok_a;
  logic ok_b;

  int n_cmp = 0;
  int n_err = 0;

  int m_col;
  int m_row;
  int img [H][W];

  vec_t tbl [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one valid pixel at the bench's frame position and record what must come out.
  task automatic px(input logic s);
    exp_t e;
    @(negedge clk);
    if (s) begin
      m_col = 0;
      m_row = 0;
    end
    sof       = s;
    din_valid = 1'b1;
    din       = 8'(m_row * 16 + m_col);
    img[m_row][m_col] = m_row * 16 + m_col;
    if (m_row >= 2) begin
      e.d    = {8'(img[m_row-2][m_col]), 8'(img[m_row-1][m_col]), 8'(img[m_row][m_col])};
      e.col  = 11'(m_col);
      e.row  = 11'(m_row);
      e.done = (m_col == W-1) && (m_row == H-1);
      q_a.push_back(e);
    end else begin
      ok_a = 1'b0;
    end
    if (m_row >= 1) begin
      e.d    = {8'h00, 8'(img[m_row-1][m_col]), 8'(img[m_row][m_col])};
      e.col  = 11'(m_col);
      e.row  = 11'(m_row);
      e.done = (m_col == W-1) && (m_row == H-1);
      q_b.push_back(e);
    end else begin
      ok_b = 1'b0;
    end
    if (m_col == W-1) begin
      m_col = 0;
      m_row = (m_row == H-1) ? 0 : m_row + 1;
    end else begin
      m_col = m_col + 1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sof       = 1'b0;
      din_valid = 1'b0;
      din       = 8'($urandom);
    end
  endtask

  task automatic sof_only();
    @(negedge clk);
    sof       = 1'b1;
    din_valid = 1'b0;
    din       = 8'($urandom);
    m_col     = 0;
    m_row     = 0;
  endtask

  task automatic clear_model();
    q_a.delete();
    q_b.delete();
    held_a = '{d: '0, col: '0, row: '0, done: 1'b0};
    held_b = '{d: '0, col: '0, row: '0, done: 1'b0};
    ok_a   = 1'b1;
    ok_b   = 1'b1;
    m_col  = 0;
    m_row  = 0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_dout_a"}, dout_a, 0);
    check({tag, "_dv_a"},   dv_a,   0);
    check({tag, "_col_a"},  col_a,  0);
    check({tag, "_row_a"},  row_a,  0);
    check({tag, "_fd_a"},   fd_a,   0);
    check({tag, "_dout_b"}, dout_b, 0);
    check({tag, "_dv_b"},   dv_b,   0);
  endtask

  // Let in-flight results come out, then nothing may remain expected.
  task automatic drain(input string tag);
    idle(3);
    check({tag, "_left_a"}, q_a.size(), 0);
    check({tag, "_left_b"}, q_b.size(), 0);
  endtask

  // Scoreboard: compare every emitted window, and held outputs during input gaps.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (rst_n) begin
      if (dv_a) begin
        if (q_a.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL a_unexpected_valid: got valid row %0d col %0d, expected none", row_a, col_a);
        end else begin
          e = q_a.pop_front();
          check("a_dout", dout_a, e.d);
          check("a_col",  col_a,  e.col);
          check("a_row",  row_a,  e.row);
          check("a_done", fd_a,   e.done);
          held_a = e;
          ok_a   = 1'b1;
        end
      end else begin
        check("a_done_idle", fd_a, 0);
        if (!din_valid && ok_a) begin
          check("a_hold_dout", dout_a, held_a.d);
          check("a_hold_col",  col_a,  held_a.col);
          check("a_hold_row",  row_a,  held_a.row);
        end
      end
      if (dv_b) begin
        if (q_b.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL b_unexpected_valid: got valid row %0d col %0d, expected none", row_b, col_b);
        end else begin
          e = q_b.pop_front();
          check("b_dout", dout_b, e.d);
          check("b_col",  col_b,  e.col);
          check("b_row",  row_b,  e.row);
          check("b_done", fd_b,   e.done);
          held_b = e;
          ok_b   = 1'b1;
        end
      end else begin
        check("b_done_idle", fd_b, 0);
        if (!din_valid && ok_b) begin
          check("b_hold_dout", dout_b, held_b.d);
        end
      end
    end
  end

  initial begin
    int n;
    int nv;

    // Continuous frame, with one gap after row 2 col 1 to see the hold.
    n = 0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        tbl[n].s   = (r == 0) && (c == 0);
        tbl[n].v   = 1'b1;
        tbl[n].xv  = (r >= 2);
        tbl[n].xd  = (r >= 2) ? {8'((r-2)*16 + c), 8'((r-1)*16 + c), 8'(r*16 + c)} : 24'h0;
        tbl[n].xc  = 11'(c);
        tbl[n].xr  = 11'(r);
        tbl[n].xf  = (r == H-1) && (c == W-1);
        tbl[n].chk = (r >= 2);
        n++;
        if (r == 2 && c == 1) begin
          tbl[n]     = tbl[n-1];
          tbl[n].s   = 1'b0;
          tbl[n].v   = 1'b0;
          tbl[n].xv  = 1'b0;
          tbl[n].xf  = 1'b0;
          n++;
        end
      end
    end

    rst_n     = 1'b0;
    sof       = 1'b0;
    din_valid = 1'b0;
    din       = '0;
    clear_model();
    #1;
    check_zero("reset");
    idle(3);
    rst_n = 1'b1;
    idle(2);

    // Table-driven continuous frame on the 3-line build.
    nv = 0;
    for (int i = 0; i < 17; i++) begin
      if (tbl[i].v) px(tbl[i].s);
      else          idle(1);
      @(posedge clk);
      #1;
      check("tbl_valid", dv_a, tbl[i].xv);
      if (tbl[i].chk) begin
        check("tbl_dout", dout_a, tbl[i].xd);
        check("tbl_col",  col_a,  tbl[i].xc);
        check("tbl_row",  row_a,  tbl[i].xr);
        check("tbl_done", fd_a,   tbl[i].xf);
      end
      if (dv_a) nv++;
    end
    check("tbl_valid_count", nv, 8);
    check("tbl_last_window", dout_a, 24'h132333);
    drain("tbl");

    // Random 50% input gaps over a full frame.
    for (int i = 0; i < W*H; i++) begin
      px(1'b0);
      idle($urandom_range(0, 1));
    end
    drain("gaps");

    // Two frames back to back; priming must restart in the second.
    for (int i = 0; i < 2*W*H; i++) px(1'b0);
    drain("b2b");

    // sof with a valid pixel at row 1 col 2 restarts the frame there.
    for (int i = 0; i < W + 2; i++) px(1'b0);
    px(1'b1);
    for (int i = 1; i < W*H; i++) px(1'b0);
    drain("sof_vld");

    // sof on an idle cycle re-homes the counters.
    for (int i = 0; i < W + 1; i++) px(1'b0);
    sof_only();
    for (int i = 0; i < W*H; i++) px(1'b0);
    drain("sof_idle");

    // Asynchronous reset at row 3 col 1, then a clean frame.
    for (int i = 0; i < 3*W + 2; i++) px(1'b0);
    #2;
    rst_n     = 1'b0;
    din_valid = 1'b0;
    sof       = 1'b0;
    clear_model();
    #1;
    check_zero("midrst");
    idle(2);
    rst_n = 1'b1;
    idle(1);
    for (int i = 0; i < W*H; i++) px(1'b0);
    drain("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
